// File: rtl/sparse_mv_sequencer_if.sv
// Handshake and control bundle between the job path, the sequencer and the accelerator.
// master = host/DMA + accelerator side, slave = sequencer.
interface sparse_mv_sequencer_if #(
    parameter int unsigned ID_W  = 4,
    parameter int unsigned CNT_W = 16
);
    logic             job_valid;
    logic             job_ready;
    logic [ID_W-1:0]  job_id;
    logic [7:0]       job_shift;
    logic             acc_clear;
    logic             acc_mac_enable;
    logic [7:0]       acc_shift;
    logic             acc_all_finished;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic             res_timeout;
    logic             busy;
    logic [CNT_W-1:0] jobs_done;

    modport master (
        output job_valid, job_id, job_shift, acc_all_finished, res_ready,
        input  job_ready, acc_clear, acc_mac_enable, acc_shift,
               res_valid, res_id, res_timeout, busy, jobs_done
    );

    modport slave (
        input  job_valid, job_id, job_shift, acc_all_finished, res_ready,
        output job_ready, acc_clear, acc_mac_enable, acc_shift,
               res_valid, res_id, res_timeout, busy, jobs_done
    );
endinterface

// File: rtl/sparse_mv_sequencer.sv
// Job-level controller for the sparse MV accelerator: clear, run with watchdog,
// drain, then hold the frozen result until the consumer takes it.
module sparse_mv_sequencer #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sparse_mv_sequencer_if.slave s_bus
);
    localparam int unsigned PH_MAX = (CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic [PH_W-1:0]  r_ph_cnt,      w_ph_nxt;
    logic [WD_W-1:0]  r_wd_cnt,      w_wd_nxt;
    logic [WD_W-1:0]  w_wd_inc;
    logic [7:0]       r_acc_shift,   w_acc_shift_nxt;
    logic [ID_W-1:0]  r_res_id,      w_res_id_nxt;
    logic             r_res_timeout, w_res_timeout_nxt;
    logic [CNT_W-1:0] r_jobs_done,   w_jobs_done_nxt;
    logic             r_job_ready,   w_job_ready_nxt;
    logic             r_acc_clear,   w_acc_clear_nxt;
    logic             r_mac_en,      w_mac_en_nxt;
    logic             r_res_valid,   w_res_valid_nxt;
    logic             r_busy,        w_busy_nxt;

    assign w_wd_inc = r_wd_cnt + WD_W'(1);

    // Next state, counters and registered-output targets
    always_comb begin
        w_state_nxt       = r_state;
        w_ph_nxt          = r_ph_cnt;
        w_wd_nxt          = r_wd_cnt;
        w_acc_shift_nxt   = r_acc_shift;
        w_res_id_nxt      = r_res_id;
        w_res_timeout_nxt = r_res_timeout;
        w_jobs_done_nxt   = r_jobs_done;

        case (r_state)
            ST_IDLE: begin
                if (s_bus.job_valid) begin
                    w_state_nxt       = ST_CLEAR;
                    w_ph_nxt          = '0;
                    w_res_id_nxt      = s_bus.job_id;
                    w_acc_shift_nxt   = s_bus.job_shift;
                    w_res_timeout_nxt = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (r_ph_cnt == PH_W'(CLR_CYC - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_wd_nxt    = '0;
                end else begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            ST_RUN: begin
                // Completion takes priority over a watchdog expiry on the same cycle
                if (s_bus.acc_all_finished) begin
                    w_state_nxt = ST_DRAIN;
                    w_ph_nxt    = '0;
                end else if (w_wd_inc == WD_W'(TIMEOUT)) begin
                    w_state_nxt       = ST_DONE;
                    w_res_timeout_nxt = 1'b1;
                end else begin
                    w_wd_nxt = w_wd_inc;
                end
            end
            ST_DRAIN: begin
                if (r_ph_cnt == PH_W'(DRAIN_CYC - 1)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end
            end
            ST_DONE: begin
                if (s_bus.res_ready) begin
                    w_state_nxt     = ST_IDLE;
                    w_jobs_done_nxt = r_jobs_done + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Control outputs are decoded from the next state so they register in step with it
        w_job_ready_nxt = (w_state_nxt == ST_IDLE);
        w_acc_clear_nxt = (w_state_nxt == ST_CLEAR);
        w_mac_en_nxt    = (w_state_nxt == ST_RUN);
        w_res_valid_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ph_cnt      <= '0;
            r_wd_cnt      <= '0;
            r_acc_shift   <= '0;
            r_res_id      <= '0;
            r_res_timeout <= 1'b0;
            r_jobs_done   <= '0;
            r_job_ready   <= 1'b1;
            r_acc_clear   <= 1'b0;
            r_mac_en      <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ph_cnt      <= w_ph_nxt;
            r_wd_cnt      <= w_wd_nxt;
            r_acc_shift   <= w_acc_shift_nxt;
            r_res_id      <= w_res_id_nxt;
            r_res_timeout <= w_res_timeout_nxt;
            r_jobs_done   <= w_jobs_done_nxt;
            r_job_ready   <= w_job_ready_nxt;
            r_acc_clear   <= w_acc_clear_nxt;
            r_mac_en      <= w_mac_en_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign s_bus.job_ready      = r_job_ready;
    assign s_bus.acc_clear      = r_acc_clear;
    assign s_bus.acc_mac_enable = r_mac_en;
    assign s_bus.acc_shift      = r_acc_shift;
    assign s_bus.res_valid      = r_res_valid;
    assign s_bus.res_id         = r_res_id;
    assign s_bus.res_timeout    = r_res_timeout;
    assign s_bus.busy           = r_busy;
    assign s_bus.jobs_done      = r_jobs_done;
endmodule

// File: tb/tb_sparse_mv_sequencer.sv
// Scoreboarded bench for sparse_mv_sequencer: directed timing checks plus a stream of jobs.
module tb_sparse_mv_sequencer;
    localparam int unsigned ID_W    = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            to;
        logic [7:0]      sh;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   exp_done;
    exp_t q[$];
    exp_t e;

    sparse_mv_sequencer_if #(.ID_W(ID_W), .CNT_W(CNT_W)) u_if ();

    sparse_mv_sequencer #(
        .ID_W(ID_W), .CLR_CYC(2), .DRAIN_CYC(2), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .s_bus(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [ID_W-1:0] id, input logic to, input logic [7:0] sh);
        exp_t r;
        r.id = id;
        r.to = to;
        r.sh = sh;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake is compared against the oldest expected entry
    always @(negedge clk) begin
        if (!reset && u_if.res_valid && u_if.res_ready) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_result", 32'(u_if.res_id), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("sb_res_id",      32'(u_if.res_id),      32'(e.id));
                chk("sb_res_timeout", 32'(u_if.res_timeout), 32'(e.to));
                chk("sb_acc_shift",   32'(u_if.acc_shift),   32'(e.sh));
            end
        end
    end

    task automatic handshake();
        u_if.res_ready = 1'b1;
        tick();
        u_if.res_ready = 1'b0;
        exp_done++;
        chk("hs_jobs_done", 32'(u_if.jobs_done), 32'(exp_done[CNT_W-1:0]));
        chk("hs_job_ready", 32'(u_if.job_ready), 32'd1);
        chk("hs_res_valid", 32'(u_if.res_valid), 32'd0);
    endtask

    // One job that completes after k RUN cycles, with optional stray completion pulses
    task automatic run_job(input logic [ID_W-1:0] id, input logic [7:0] sh,
                           input int k, input int stall, input bit inj);
        int n;
        u_if.job_valid = 1'b1;
        u_if.job_id    = id;
        u_if.job_shift = sh;
        q.push_back(mk(id, 1'b0, sh));
        n = 0;
        while (!u_if.job_ready && n < 50) begin
            tick();
            n++;
        end
        chk("job_accept_wait", 32'(u_if.job_ready), 32'd1);
        tick();
        u_if.job_valid = 1'b0;
        for (int c = 0; c <= k + 4; c++) begin
            if (c == k + 1) chk("rj_mac_on",   32'(u_if.acc_mac_enable), 32'd1);
            if (c == k + 2) chk("rj_mac_off",  32'(u_if.acc_mac_enable), 32'd0);
            if (c == k + 3) chk("rj_rv_early", 32'(u_if.res_valid), 32'd0);
            if (c == k + 4) chk("rj_rv_on",    32'(u_if.res_valid), 32'd1);
            if (c == 0)     u_if.acc_all_finished = inj;
            if (c == 1)     u_if.acc_all_finished = 1'b0;
            if (c == k + 1) u_if.acc_all_finished = 1'b1;
            if (c == k + 2) u_if.acc_all_finished = inj;
            if (c == k + 3) u_if.acc_all_finished = 1'b0;
            if (c < k + 4) tick();
        end
        repeat (stall) tick();
        handshake();
        if (inj) begin
            u_if.acc_all_finished = 1'b1;
            tick();
            u_if.acc_all_finished = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit actual=expired expected=finish");
        $fatal(1, "time limit");
    end

    initial begin
        checks   = 0;
        failures = 0;
        exp_done = 0;
        reset    = 1'b1;
        u_if.job_valid        = 1'b0;
        u_if.job_id           = '0;
        u_if.job_shift        = '0;
        u_if.acc_all_finished = 1'b0;
        u_if.res_ready        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_job_ready", 32'(u_if.job_ready), 32'd1);
        chk("rst_busy",      32'(u_if.busy),      32'd0);
        chk("rst_clear",     32'(u_if.acc_clear), 32'd0);
        chk("rst_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("rst_jobs_done", 32'(u_if.jobs_done), 32'd0);
        reset = 1'b0;
        tick();

        // Basic job: id 5, shift 3, completion seen on the 8th RUN cycle
        u_if.job_valid = 1'b1;
        u_if.job_id    = 4'd5;
        u_if.job_shift = 8'd3;
        q.push_back(mk(4'd5, 1'b0, 8'd3));
        tick();
        u_if.job_valid = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            chk("basic_clear", 32'(u_if.acc_clear),      32'(c <= 1));
            chk("basic_mac",   32'(u_if.acc_mac_enable), 32'(c >= 2 && c <= 9));
            chk("basic_rv",    32'(u_if.res_valid),      32'(c >= 12));
            if (c == 9)  u_if.acc_all_finished = 1'b1;
            if (c == 10) u_if.acc_all_finished = 1'b0;
            if (c < 12) tick();
        end
        chk("basic_res_id",  32'(u_if.res_id),      32'd5);
        chk("basic_timeout", 32'(u_if.res_timeout), 32'd0);
        chk("basic_shift",   32'(u_if.acc_shift),   32'd3);

        // Backpressure with a competing request held that must not be taken
        u_if.job_valid = 1'b1;
        u_if.job_id    = 4'd9;
        u_if.job_shift = 8'd7;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_rv",        32'(u_if.res_valid),      32'd1);
            chk("bp_res_id",    32'(u_if.res_id),         32'd5);
            chk("bp_mac",       32'(u_if.acc_mac_enable), 32'd0);
            chk("bp_job_ready", 32'(u_if.job_ready),      32'd0);
        end
        chk("bp_shift_held", 32'(u_if.acc_shift), 32'd3);
        handshake();
        chk("bp_busy", 32'(u_if.busy), 32'd0);

        // Timeout: held request accepted now, never completes
        q.push_back(mk(4'd9, 1'b1, 8'd7));
        tick();
        u_if.job_valid = 1'b0;
        chk("to_clear",   32'(u_if.acc_clear), 32'd1);
        chk("to_shift",   32'(u_if.acc_shift), 32'd7);
        chk("to_busy",    32'(u_if.busy),      32'd1);
        for (int c = 0; c <= 18; c++) begin
            chk("to_mac", 32'(u_if.acc_mac_enable), 32'(c >= 2 && c <= 17));
            chk("to_rv",  32'(u_if.res_valid),      32'(c >= 18));
            if (c < 18) tick();
        end
        chk("to_flag",   32'(u_if.res_timeout), 32'd1);
        chk("to_res_id", 32'(u_if.res_id),      32'd9);
        handshake();

        // Race: completion on the 16th RUN cycle beats the watchdog
        u_if.job_valid = 1'b1;
        u_if.job_id    = 4'd2;
        u_if.job_shift = 8'd1;
        q.push_back(mk(4'd2, 1'b0, 8'd1));
        tick();
        u_if.job_valid = 1'b0;
        chk("race_to_cleared", 32'(u_if.res_timeout), 32'd0);
        for (int c = 0; c <= 20; c++) begin
            chk("race_mac", 32'(u_if.acc_mac_enable), 32'(c >= 2 && c <= 17));
            chk("race_rv",  32'(u_if.res_valid),      32'(c >= 20));
            if (c == 17) u_if.acc_all_finished = 1'b1;
            if (c == 18) u_if.acc_all_finished = 1'b0;
            if (c < 20) tick();
        end
        chk("race_timeout", 32'(u_if.res_timeout), 32'd0);
        handshake();

        // Reset four cycles into RUN drops the job
        u_if.job_valid = 1'b1;
        u_if.job_id    = 4'd11;
        u_if.job_shift = 8'd4;
        tick();
        u_if.job_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_mac", 32'(u_if.acc_mac_enable), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_job_ready", 32'(u_if.job_ready),      32'd1);
        chk("mr_clear",     32'(u_if.acc_clear),      32'd0);
        chk("mr_mac",       32'(u_if.acc_mac_enable), 32'd0);
        chk("mr_rv",        32'(u_if.res_valid),      32'd0);
        chk("mr_timeout",   32'(u_if.res_timeout),    32'd0);
        chk("mr_busy",      32'(u_if.busy),           32'd0);
        chk("mr_jobs_done", 32'(u_if.jobs_done),      32'd0);
        chk("mr_res_id",    32'(u_if.res_id),         32'd0);
        chk("mr_shift",     32'(u_if.acc_shift),      32'd0);
        tick();
        reset    = 1'b0;
        exp_done = 0;
        tick();
        run_job(4'd12, 8'd6, 5, 1, 1'b1);

        // Stream of jobs from a clean reset
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        exp_done = 0;
        tick();
        for (int j = 0; j < 300; j++) begin
            run_job(4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)),
                    int'($urandom_range(16, 1)), int'($urandom_range(4, 0)),
                    1'($urandom_range(1, 0)));
        end
        chk("stream_jobs_done", 32'(u_if.jobs_done), 32'd300);
        tick();
        chk("sb_queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sparse_mv_sequencer.md
# sparse_mv_sequencer

Job-level controller for the sparse matrix-vector accelerator. It accepts one job at a time over a valid/ready handshake and drives the accelerator's clear, MAC-enable and result-shift controls. It watches the accelerator's completion flag, freezes and settles the accumulators, and presents a result-ready handshake downstream. It sits between the host/DMA command path and the accelerator; operand buses (activations, w/p/z arrays) are not routed through it.

## Interface
- ID_W, 4, job tag width
- CLR_CYC, 2, cycles acc_clear is held high (must be ≥2: accelerator registers clear internally)
- DRAIN_CYC, 2, settle cycles after completion before result is offered (≥1)
- TIMEOUT, 1024, max RUN cycles before job is aborted
- CNT_W, 16, completed-job counter width

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  job request
- job_ready  out  1  sequencer can accept a job
- job_id  in  ID_W  job tag
- job_shift  in  8  result right-shift amount
- acc_clear  out  1  to accelerator PE_clear_acc
- acc_mac_enable  out  1  to accelerator PE_mac_enable
- acc_shift  out  8  to accelerator PE_res_shift_num
- acc_all_finished  in  1  accelerator completion flag
- res_valid  out  1  accelerator results stable and frozen
- res_ready  in  1  consumer has taken results
- res_id  out  ID_W  tag of the offered result
- res_timeout  out  1  job ended by watchdog, results invalid
- busy  out  1  state ≠ IDLE
- jobs_done  out  CNT_W  count of res handshakes, wraps

## Operation
- All outputs registered. Reset values: job_ready=1, all other outputs 0, state IDLE.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: job_ready=1. On job_valid: latch job_id→res_id, job_shift→acc_shift; clear res_timeout; go CLEAR; job_ready→0.
- CLEAR: acc_clear=1, acc_mac_enable=0 for exactly CLR_CYC cycles; then RUN.
- RUN: acc_mac_enable=1; watchdog counts RUN cycles (width clog2(TIMEOUT+1)). acc_all_finished=1 → DRAIN. Counter reaching TIMEOUT without completion → DONE with res_timeout=1, acc_mac_enable=0.
- acc_all_finished is ignored outside RUN.
- DRAIN: acc_mac_enable=0 (accumulators frozen) for DRAIN_CYC cycles; then DONE.
- DONE: res_valid=1, res_id/res_timeout held, acc_mac_enable=0. On res_ready: res_valid→0, jobs_done+1 (wraps at 2^CNT_W), go IDLE.
- acc_shift holds the latched value until the next job is accepted.
- Upstream holds operand buses stable from job accept until the res handshake. The sequencer does not check this.

## Timing
- Job accepted at edge T: acc_clear high cycles T+1..T+CLR_CYC; acc_mac_enable high from T+CLR_CYC+1.
- acc_all_finished sampled high at edge F: acc_mac_enable low from F+1; res_valid high from F+DRAIN_CYC+1.
- Timeout: res_valid high the cycle after the TIMEOUT-th RUN cycle.
- Result handshake at edge H: job_ready high from H+1. A job_valid presented at H is not accepted; it is taken at H+1 at the earliest. No job overlap.
- Completion and timeout on the same cycle: completion wins (DRAIN, res_timeout=0).
- res_ready while res_valid=0: ignored.
- reset mid-job: immediate return to reset values. The in-flight job is dropped with no result. jobs_done returns to 0.
- job_valid while job_ready=0: ignored; the request must be held by upstream.

## Test plan
- Basic job (CLR_CYC=2, DRAIN_CYC=2): job_id=5, job_shift=3 accepted at T; model asserts all_finished at T+10 -> acc_clear high T+1..T+2, mac_enable high T+3..T+10, res_valid at T+13 with res_id=5, res_timeout=0, acc_shift=3.
- Backpressure: hold res_ready=0 for 20 cycles -> res_valid, res_id and mac_enable=0 stable; job_ready stays 0. Then res_ready=1 -> jobs_done 0→1, job_ready=1 next cycle.
- Timeout (TIMEOUT=16): all_finished never asserted -> res_valid with res_timeout=1 exactly after 16 RUN cycles. The next job clears res_timeout.
- Race: all_finished asserted on the 16th RUN cycle with TIMEOUT=16 -> DRAIN path, res_timeout=0.
- Reset mid-RUN: assert reset 4 cycles into RUN -> all outputs at reset values asynchronously, jobs_done=0. A following job completes normally.
- Back-to-back: 300 random jobs with random finish latency and res_ready stalls -> res_id sequence matches job order, jobs_done=300 mod 2^CNT_W. acc_all_finished pulses injected during CLEAR/DRAIN/IDLE have no effect.
